cache_data_array: RTL

//  Parametrised L1 cache data store. Holds LINES lines of WORDS words each and has three ports:
//  - registered line read port;
//  - CPU write-hit port, word-granular with byte enables;
//  - refill engine that collects a line from memory over BEATS beats and commits it atomically.

---
 rtl/cache_data_array_if.sv | 49 ++++
 rtl/cache_data_array.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cache_data_array_if.sv
// cache_data_array_if
//   Bundles the three access ports of the cache data store: the registered
//   line read port, the CPU write-hit port and the memory refill port.
//   master : cache controller / CPU store path / refill bus (drives requests)
//   slave  : cache_data_array (drives read data, ready and status)
interface cache_data_array_if #(
    parameter int unsigned LINES  = 32,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned BEAT_W = 32
);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned OFF_W  = $clog2(WORDS);
    localparam int unsigned LINE_W = WORDS * WORD_W;
    localparam int unsigned BE_W   = WORD_W / 8;

    // read port
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [LINE_W-1:0] rd_line;
    logic              rd_valid;
    // CPU write-hit port
    logic              wr_en;
    logic              wr_ready;
    logic [IDX_W-1:0]  wr_idx;
    logic [OFF_W-1:0]  wr_off;
    logic [BE_W-1:0]   wr_be;
    logic [WORD_W-1:0] wr_data;
    // refill port
    logic              fill_start;
    logic [IDX_W-1:0]  fill_idx;
    logic              fill_valid;
    logic              fill_ready;
    logic [BEAT_W-1:0] fill_data;
    logic              fill_busy;
    logic              fill_done;

    modport master (
        output rd_en, rd_idx, wr_en, wr_idx, wr_off, wr_be, wr_data,
               fill_start, fill_idx, fill_valid, fill_data,
        input  rd_line, rd_valid, wr_ready, fill_ready, fill_busy, fill_done
    );

    modport slave (
        input  rd_en, rd_idx, wr_en, wr_idx, wr_off, wr_be, wr_data,
               fill_start, fill_idx, fill_valid, fill_data,
        output rd_line, rd_valid, wr_ready, fill_ready, fill_busy, fill_done
    );
endinterface

// File: rtl/cache_data_array.sv
// cache_data_array
//   L1 cache data store of LINES lines x WORDS words. Three ports:
//   - registered line read (rd_line valid the cycle after rd_en);
//   - CPU write-hit, byte-enabled within one word, stalled only when it
//     targets the line currently being refilled;
//   - refill engine that gathers BEATS beats into a staging buffer and
//     commits the whole line to the array on the last beat.
//   Ports: clk, rst_n (async, active low), bus (cache_data_array_if.slave).
module cache_data_array #(
    parameter int unsigned LINES  = 32,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned BEAT_W = 32
) (
    input logic                clk,
    input logic                rst_n,
    cache_data_array_if.slave  bus
);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned LINE_W = WORDS * WORD_W;
    localparam int unsigned BE_W   = WORD_W / 8;
    localparam int unsigned BEATS  = LINE_W / BEAT_W;
    localparam int unsigned CNT_W  = $clog2(BEATS);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
    logic               fill_done_q, fill_done_d;
    logic [LINE_W-1:0]  buf_q, buf_d;
    logic [LINE_W-1:0]  rd_line_q, rd_line_d;
    logic               rd_valid_q;

    logic [LINE_W-1:0]  mem_q [LINES];

    logic               commit;
    logic               wr_ready;
    logic               wr_fire;
    logic [LINE_W-1:0]  wr_line;

    // ---------------- refill FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            fill_idx_q  <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            fill_idx_q  <= fill_idx_d;
            fill_done_q <= fill_done_d;
        end
    end

    // Staging buffer carries no reset: only beats of the current refill are
    // ever committed from it.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        fill_idx_d  = fill_idx_q;
        fill_done_d = 1'b0;
        buf_d       = buf_q;
        commit      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.fill_start) begin
                    fill_idx_d = bus.fill_idx;
                    beat_cnt_d = '0;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.fill_valid) begin
                    buf_d[32'(beat_cnt_q) * BEAT_W +: BEAT_W] = bus.fill_data;
                    if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                        // buf_d already includes the final beat, so it is
                        // the complete line written at this edge.
                        commit      = 1'b1;
                        beat_cnt_d  = '0;
                        state_d     = S_IDLE;
                        fill_done_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.fill_busy  = (state_q == S_FILL);
    assign bus.fill_ready = (state_q == S_FILL);
    assign bus.fill_done  = fill_done_q;

    // ---------------- CPU write-hit ----------------
    assign wr_ready     = !((state_q == S_FILL) && (bus.wr_idx == fill_idx_q));
    assign bus.wr_ready = wr_ready;
    assign wr_fire      = bus.wr_en && wr_ready;

    always_comb begin
        wr_line = mem_q[bus.wr_idx];
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (bus.wr_be[b]) begin
                wr_line[32'(bus.wr_off) * WORD_W + b * 8 +: 8] = bus.wr_data[b * 8 +: 8];
            end
        end
    end

    // A CPU write and a commit never target the same line (wr_ready blocks
    // it), so the two updates below are independent.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (commit) begin
                mem_q[fill_idx_q] <= buf_d;
            end
            if (wr_fire) begin
                mem_q[bus.wr_idx] <= wr_line;
            end
        end
    end

    // ---------------- read port (write-first) ----------------
    always_comb begin
        rd_line_d = mem_q[bus.rd_idx];
        if (commit && (bus.rd_idx == fill_idx_q)) begin
            rd_line_d = buf_d;
        end else if (wr_fire && (bus.rd_idx == bus.wr_idx)) begin
            rd_line_d = wr_line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_line_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_line_q <= rd_line_d;
            end
        end
    end

    assign bus.rd_line  = rd_line_q;
    assign bus.rd_valid = rd_valid_q;

endmodule
